// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory line arbiter.
//   arb_state_t   : arbiter FSM states (IDLE -> I_BUSY | D_BUSY -> RESP -> IDLE)
//   arb_grant_t   : which client owns the current transaction
//   LINE_OFFSET_W : byte-offset bits inside one cacheline (32-byte lines)
package rv32i_types;

    localparam int LINE_OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } arb_grant_t;

endpackage

// File: rtl/pmem_arbiter_if.sv
// Bundle of every client-side and memory-side signal of the line arbiter.
//   slave  : arbiter view (takes cache requests, drives the pmem port)
//   master : environment view (caches and cacheline adaptor)
//
// Handshake: a requester raises its read/write strobe with address (and
// write line) and holds them until its one-cycle resp pulse; the line on
// *_rdata is valid only in that resp cycle. On the memory side the arbiter
// holds pmem_read/pmem_write/pmem_address/pmem_wdata stable until the
// adaptor returns a single-cycle pmem_resp (with pmem_rdata for reads).
interface pmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_read, i_address,
        output i_rdata, i_resp,
        input  d_read, d_write, d_address, d_wdata,
        output d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output i_read, i_address,
        input  i_rdata, i_resp,
        output d_read, d_write, d_address, d_wdata,
        input  d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/pmem_arb_sel.sv
// Combinational winner pick between I-cache and D-cache requests.
//   i_req_i      : I-cache request pending
//   i_req_d      : D-cache request pending (read or write)
//   i_last_grant : previous winner (only with ARB_ROUND_ROBIN_EN)
//   o_grant      : chosen side; meaningful only when a request is pending
// Build option: ARB_ROUND_ROBIN_EN -> alternate on contention,
// otherwise fixed D-over-I priority.
module pmem_arb_sel
    import rv32i_types::*;
(
    input  logic       i_req_i,
    input  logic       i_req_d,
`ifdef ARB_ROUND_ROBIN_EN
    input  arb_grant_t i_last_grant,
`endif
    output arb_grant_t o_grant
);

    always_comb begin
        o_grant = GRANT_I;
`ifdef ARB_ROUND_ROBIN_EN
        if (i_req_i && i_req_d) begin
            // Contention: hand the grant to the side that did not win last.
            o_grant = (i_last_grant == GRANT_D) ? GRANT_I : GRANT_D;
        end else if (i_req_d) begin
            o_grant = GRANT_D;
        end else if (i_req_i) begin
            o_grant = GRANT_I;
        end
`else
        if (i_req_d) begin
            o_grant = GRANT_D;
        end else if (i_req_i) begin
            o_grant = GRANT_I;
        end
`endif
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Merges I-cache and D-cache line misses onto the single pmem line port.
// One transaction at a time: the winner's op/address/line are latched in
// IDLE, replayed to the adaptor while busy, and a one-cycle resp plus the
// captured line are returned to the winner.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : pmem_arbiter_if.slave (cache requests + pmem port)
//   o_dbg_state : current FSM state, for observation only
// Build option: ARB_ROUND_ROBIN_EN (round-robin on contention, adds
// last_grant register); undefined gives fixed D-over-I priority.
module pmem_arbiter
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,   // must match the interface instance
    parameter int LINE_W = 256
)(
    input  logic                clk,
    input  logic                rst,
    pmem_arbiter_if.slave       bus,
    output arb_state_t          o_dbg_state
);

    // Clears the byte offset so pmem only ever sees line-aligned addresses.
    localparam logic [ADDR_W-1:0] LINE_MASK =
        {{(ADDR_W-LINE_OFFSET_W){1'b1}}, {LINE_OFFSET_W{1'b0}}};

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    arb_grant_t        r_owner;
    logic              r_op_write;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_line;

    logic              w_req_i;
    logic              w_req_d;
    logic              w_take;
    logic              w_busy;
    arb_grant_t        w_grant;

    assign w_req_i = bus.i_read;
    assign w_req_d = bus.d_read | bus.d_write;
    assign w_take  = (r_state == IDLE) && (w_req_i || w_req_d);
    assign w_busy  = (r_state == I_BUSY) || (r_state == D_BUSY);

`ifdef ARB_ROUND_ROBIN_EN
    arb_grant_t r_last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= GRANT_I;
        end else if (w_take) begin
            r_last_grant <= w_grant;
        end
    end
`endif

    pmem_arb_sel u_sel (
        .i_req_i      (w_req_i),
        .i_req_d      (w_req_d),
`ifdef ARB_ROUND_ROBIN_EN
        .i_last_grant (r_last_grant),
`endif
        .o_grant      (w_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        bus.i_resp       = 1'b0;
        bus.d_resp       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_next_state = (w_grant == GRANT_D) ? D_BUSY : I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                // Only latched copies reach pmem, so client changes are invisible.
                bus.pmem_read    = ~r_op_write;
                bus.pmem_write   = r_op_write;
                bus.pmem_address = r_addr;
                bus.pmem_wdata   = r_wdata;
                if (bus.pmem_resp) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                bus.i_resp   = (r_owner == GRANT_I);
                bus.d_resp   = (r_owner == GRANT_D);
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Transaction latch and line buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner    <= GRANT_I;
            r_op_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_line     <= '0;
        end else begin
            if (w_take) begin
                r_owner <= w_grant;
                if (w_grant == GRANT_D) begin
                    // d_read together with d_write is a write.
                    r_op_write <= bus.d_write;
                    r_addr     <= bus.d_address & LINE_MASK;
                    r_wdata    <= bus.d_wdata;
                end else begin
                    r_op_write <= 1'b0;
                    r_addr     <= bus.i_address & LINE_MASK;
                    r_wdata    <= '0;
                end
            end
            if (w_busy && bus.pmem_resp && !r_op_write) begin
                r_line <= bus.pmem_rdata;
            end
        end
    end

    assign bus.i_rdata  = r_line;
    assign bus.d_rdata  = r_line;
    assign o_dbg_state  = r_state;

endmodule
